// File: rtl/hazard_detection_unit_pkg.sv
// hazard_detection_unit_pkg: shared widths and result latencies; FORWARDING_EN selects bypass-aware latencies
package hazard_detection_unit_pkg;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS = 8;
    localparam int RDY_W = 2;
`ifdef FORWARDING_EN
    localparam logic [RDY_W-1:0] LAT_ALU = 2'd0;
    localparam logic [RDY_W-1:0] LAT_LOAD = 2'd1;
`else
    localparam logic [RDY_W-1:0] LAT_ALU = 2'd2;
    localparam logic [RDY_W-1:0] LAT_LOAD = 2'd2;
`endif
endpackage

// File: rtl/hazard_detection_unit_reg_ready_counter.sv
// reg_ready_counter: per-register cycles-until-forwardable countdown with load, decrement and hold
module reg_ready_counter
    import hazard_detection_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [RDY_W-1:0] lat,
    output logic [RDY_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (en) cnt <= load ? lat : (cnt != '0 ? cnt - RDY_W'(1) : '0);
    end
endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: issue-side stall/bubble/flush control with stall counter; FORWARDING_EN selects latencies
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_reg_write,
    input  logic [REG_ADDR_W-1:0] id_write_reg,
    input  logic                  id_is_load,
    input  logic                  pipe_freeze,
    input  logic                  ex_branch_taken,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic                  flush_id,
    output logic                  issue,
    output logic [CNT_W-1:0]      stall_cycles
);
    logic [NUM_REGS-1:0][RDY_W-1:0] cnt;
    logic hazard, live, frz, flush, stall;
    assign cnt[0] = '0;
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        reg_ready_counter u_cnt (
            .clk (clk),
            .rst (rst),
            .en  (!pipe_freeze),
            .load(issue && id_reg_write && id_write_reg == REG_ADDR_W'(r)),
            .lat (id_is_load ? LAT_LOAD : LAT_ALU),
            .cnt (cnt[r])
        );
    end
    // r0 has a permanently zero counter, so it can never raise a hazard
    always_comb begin
        hazard = id_valid && ((id_uses_rs && cnt[id_rs] != '0) || (id_uses_rt && cnt[id_rt] != '0));
        live = !rst && !pipe_freeze;
        frz = !rst && pipe_freeze;
        flush = live && ex_branch_taken;
        stall = live && !ex_branch_taken && hazard;
        issue = live && !ex_branch_taken && !hazard && id_valid;
        stall_if = frz || stall;
        stall_id = frz || stall;
        bubble_ex = flush || stall;
        flush_id = flush;
    end
    always_ff @(posedge clk) begin
        if (rst) stall_cycles <= '0;
        else if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
    end
endmodule
